// File: rtl/conv_mem_responder.sv
// conv_mem_responder
//   Memory-side responder for the convolution accelerator. Holds the image
//   ROM (loaded from a host stream), the layer-0 RAM and the layer-1 RAM.
//   Sequence: LOAD image -> START pulse -> RUN (serve accelerator traffic
//   until busy drops) -> DUMP_L0 -> DUMP_L1 -> FIN.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   img_valid/img_data/img_ready   host image stream (valid/ready)
//   ready                      one-cycle start pulse to the accelerator
//   busy                       accelerator busy
//   iaddr/idata                combinational image read port
//   csel/cwr/caddr_wr/cdata_wr layer write port (001 = L0, 011 = L1)
//   crd/caddr_rd/cdata_rd      combinational layer read port
//   dump_valid/dump_ready/dump_sel/dump_addr/dump_data  layer dump stream
//   done                       dump finished (sticky)
//   err                        protocol error (sticky)
module conv_mem_responder #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int L1_AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_valid,
    input  logic [DW-1:0] img_data,
    output logic          img_ready,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic [2:0]    csel,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          dump_sel,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_RUN, S_DUMP_L0, S_DUMP_L1, S_FIN
    } state_t;

    localparam logic [2:0]    SEL_L0   = 3'b001;
    localparam logic [2:0]    SEL_L1   = 3'b011;
    localparam logic [AW-1:0] IMG_LAST = '1;
    localparam logic [AW-1:0] L1_LAST  = AW'({L1_AW{1'b1}});

    logic [DW-1:0] img_mem [0:(1<<AW)-1];
    logic [DW-1:0] l0_mem  [0:(1<<AW)-1];
    logic [DW-1:0] l1_mem  [0:(1<<L1_AW)-1];

    state_t        state, state_nxt;
    logic [AW-1:0] load_cnt;
    logic [1:0]    blank_cnt;
    logic          img_accept, dump_hs, sel_legal, err_set;
    logic          img_ready_nxt, ready_nxt, done_nxt, dump_valid_nxt;
    logic          fetch_en, fetch_sel;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_word;

    assign img_accept = (state == S_LOAD) && img_valid && img_ready;
    assign dump_hs    = dump_valid && dump_ready;
    assign sel_legal  = (csel == SEL_L0) || (csel == SEL_L1);
    assign err_set    = (cwr && ((state != S_RUN) || !sel_legal)) || (crd && !sel_legal);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (img_accept && load_cnt == IMG_LAST) state_nxt = S_START;
            S_START:   state_nxt = S_RUN;
            // busy is only looked at once the two-cycle blanking window is over
            S_RUN:     if (blank_cnt == 2'd2 && !busy) state_nxt = S_DUMP_L0;
            S_DUMP_L0: if (dump_hs && dump_addr == IMG_LAST) state_nxt = S_DUMP_L1;
            S_DUMP_L1: if (dump_hs && dump_addr == L1_LAST) state_nxt = S_FIN;
            S_FIN:     state_nxt = S_FIN;
            default:   state_nxt = S_LOAD;
        endcase
    end

    // Output logic: next values of the registered outputs plus the dump fetch.
    // The dump word register is loaded either on the first cycle of the dump
    // (dump_valid still low) or on a handshake, so a new word follows each
    // accept without a bubble, including across the L0 -> L1 boundary.
    always_comb begin
        img_ready_nxt  = (state_nxt == S_LOAD);
        ready_nxt      = (state_nxt == S_START);
        done_nxt       = (state_nxt == S_FIN);
        dump_valid_nxt = 1'b0;
        fetch_en       = 1'b0;
        fetch_sel      = dump_sel;
        fetch_addr     = dump_addr;
        if (state == S_DUMP_L0 || state == S_DUMP_L1) begin
            dump_valid_nxt = (state_nxt != S_FIN);
            if (!dump_valid) begin
                fetch_en  = 1'b1;
                fetch_sel = (state == S_DUMP_L1);
            end else if (dump_hs) begin
                if (state == S_DUMP_L0 && state_nxt == S_DUMP_L1) begin
                    fetch_en   = 1'b1;
                    fetch_sel  = 1'b1;
                    fetch_addr = '0;
                end else if (state_nxt != S_FIN) begin
                    fetch_en   = 1'b1;
                    fetch_addr = dump_addr + AW'(1);
                end
            end
        end
    end

    always_comb begin
        if (fetch_sel) fetch_word = l1_mem[fetch_addr[L1_AW-1:0]];
        else           fetch_word = l0_mem[fetch_addr];
    end

    // Registered outputs and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt   <= '0;
            blank_cnt  <= '0;
            img_ready  <= 1'b0;
            ready      <= 1'b0;
            dump_valid <= 1'b0;
            dump_sel   <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            img_ready  <= img_ready_nxt;
            ready      <= ready_nxt;
            done       <= done_nxt;
            dump_valid <= dump_valid_nxt;
            err        <= err | err_set;
            if (img_accept) load_cnt <= load_cnt + AW'(1);
            if (state != S_RUN)          blank_cnt <= '0;
            else if (blank_cnt != 2'd2)  blank_cnt <= blank_cnt + 2'd1;
            if (fetch_en) begin
                dump_sel  <= fetch_sel;
                dump_addr <= fetch_addr;
                dump_data <= fetch_word;
            end
        end
    end

    // Memory arrays are never cleared
    always_ff @(posedge clk) begin
        if (img_accept) img_mem[load_cnt] <= img_data;
        if (state == S_RUN && cwr) begin
            if (csel == SEL_L0)      l0_mem[caddr_wr] <= cdata_wr;
            else if (csel == SEL_L1) l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        end
    end

    assign idata = img_mem[iaddr];

    always_comb begin
        cdata_rd = '0;
        if (crd && csel == SEL_L0)      cdata_rd = l0_mem[caddr_rd];
        else if (crd && csel == SEL_L1) cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
module tb_conv_mem_responder;
    localparam int DW = 20;
    localparam int AW = 12;
    localparam int L1_AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          img_valid, img_ready, ready, busy;
    logic [DW-1:0] img_data, idata, cdata_wr, cdata_rd, dump_data;
    logic [AW-1:0] iaddr, caddr_wr, caddr_rd, dump_addr;
    logic [2:0]    csel;
    logic          cwr, crd, dump_valid, dump_ready, dump_sel, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_l0 [0:4095];
    logic [DW-1:0] exp_l1 [0:1023];

    always #5 clk = ~clk;

    conv_mem_responder #(.DW(DW), .AW(AW), .L1_AW(L1_AW)) dut (
        .clk(clk), .reset(reset),
        .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_sel(dump_sel),
        .dump_addr(dump_addr), .dump_data(dump_data), .done(done), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        img_valid = 1'b0; img_data = '0; busy = 1'b1; iaddr = '0;
        csel = 3'b000; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        crd = 1'b0; caddr_rd = '0; dump_ready = 1'b0;
    endtask

    // Streams 4096 words base+i; returns after the edge that takes the last one.
    task automatic load_image(input bit gappy, input logic [DW-1:0] base, output int accepts);
        int cyc;
        cyc = 0;
        accepts = 0;
        while (accepts < 4096 && cyc < 10000) begin
            img_valid = gappy ? ((cyc % 3) != 2) : 1'b1;
            img_data  = base + DW'(accepts);
            if (img_valid && img_ready) accepts++;
            tick;
            cyc++;
        end
        img_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs;
        #2 reset = 1'b0;
        #10;
        n_cmp++; if (img_ready !== 1'b0) begin n_bad++; $display("FAIL rst_img_ready: got %0b want 0", img_ready); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", ready); end
        n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dump_valid: got %0b want 0", dump_valid); end
        n_cmp++; if (dump_sel !== 1'b0) begin n_bad++; $display("FAIL rst_dump_sel: got %0b want 0", dump_sel); end
        n_cmp++; if (dump_addr !== 12'h000) begin n_bad++; $display("FAIL rst_dump_addr: got %0h want 0", dump_addr); end
        n_cmp++; if (dump_data !== 20'h00000) begin n_bad++; $display("FAIL rst_dump_data: got %0h want 0", dump_data); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b want 0", err); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (img_ready !== 1'b0) begin n_bad++; $display("FAIL rst_img_ready_pre_edge: got %0b want 0", img_ready); end
        tick;
        n_cmp++; if (img_ready !== 1'b1) begin n_bad++; $display("FAIL rst_img_ready_rise: got %0b want 1", img_ready); end
    endtask

    task automatic test_load;
        int acc;
        load_image(1'b1, 20'h00000, acc);
        n_cmp++; if (acc !== 4096) begin n_bad++; $display("FAIL load_accepts: got %0d want 4096", acc); end
        n_cmp++; if (img_ready !== 1'b0) begin n_bad++; $display("FAIL load_img_ready_low: got %0b want 0", img_ready); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_pulse: got %0b want 1", ready); end
        iaddr = 12'h0A5; #1;
        n_cmp++; if (idata !== 20'h000A5) begin n_bad++; $display("FAIL idata_0A5: got %0h want 000a5", idata); end
        iaddr = 12'hFFF; #1;
        n_cmp++; if (idata !== 20'h00FFF) begin n_bad++; $display("FAIL idata_FFF: got %0h want 00fff", idata); end
        tick;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ready_one_cycle: got %0b want 0", ready); end
    endtask

    // Entered on the first RUN cycle: busy low only there must not end RUN.
    task automatic test_run_blanking;
        busy = 1'b0;
        tick;
        busy = 1'b1;
        tick; tick; tick;
        n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL blank_still_run: dump_valid got %0b want 0", dump_valid); end
    endtask

    task automatic test_layer_fill;
        for (int a = 0; a < 4096; a++) begin
            cwr = 1'b1; csel = 3'b001; caddr_wr = AW'(a);
            cdata_wr = {8'hA5, 12'(a)};
            exp_l0[a] = {8'hA5, 12'(a)};
            tick;
        end
        for (int a = 0; a < 1024; a++) begin
            cwr = 1'b1; csel = 3'b011; caddr_wr = AW'(a) | 12'h800;
            cdata_wr = {10'h2C3, 10'(a)};
            exp_l1[a] = {10'h2C3, 10'(a)};
            tick;
        end
        cwr = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fill_err: got %0b want 0", err); end
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'h123; #1;
        n_cmp++; if (cdata_rd !== 20'hA5123) begin n_bad++; $display("FAIL fill_l0_123: got %0h want a5123", cdata_rd); end
        csel = 3'b011; caddr_rd = 12'h3FF; #1;
        n_cmp++; if (cdata_rd !== 20'hB0FFF) begin n_bad++; $display("FAIL fill_l1_3ff: got %0h want b0fff", cdata_rd); end
        caddr_rd = 12'hC05; #1;
        n_cmp++; if (cdata_rd !== 20'hB0C05) begin n_bad++; $display("FAIL fill_l1_alias: got %0h want b0c05", cdata_rd); end
        crd = 1'b0;
        tick;
    endtask

    task automatic test_layer_rw;
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h7FF; cdata_wr = 20'h13100;
        crd = 1'b1; caddr_rd = 12'h7FF; #1;
        n_cmp++; if (cdata_rd !== 20'hA57FF) begin n_bad++; $display("FAIL rw_same_cycle_old: got %0h want a57ff", cdata_rd); end
        tick;
        cwr = 1'b0; #1;
        exp_l0[12'h7FF] = 20'h13100;
        n_cmp++; if (cdata_rd !== 20'h13100) begin n_bad++; $display("FAIL rw_next_cycle_new: got %0h want 13100", cdata_rd); end
        crd = 1'b0; #1;
        n_cmp++; if (cdata_rd !== 20'h00000) begin n_bad++; $display("FAIL rd_idle_zero: got %0h want 0", cdata_rd); end
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'hC05; cdata_wr = 20'hFFFFF;
        tick;
        cwr = 1'b0; exp_l1[5] = 20'hFFFFF;
        crd = 1'b1; caddr_rd = 12'h005; #1;
        n_cmp++; if (cdata_rd !== 20'hFFFFF) begin n_bad++; $display("FAIL l1_write_005: got %0h want fffff", cdata_rd); end
        csel = 3'b001; #1;
        n_cmp++; if (cdata_rd !== 20'hA5005) begin n_bad++; $display("FAIL l0_005_untouched: got %0h want a5005", cdata_rd); end
        crd = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rw_err_clear: got %0b want 0", err); end
        tick;
    endtask

    task automatic test_csel_err;
        cwr = 1'b1; csel = 3'b010; caddr_wr = 12'h005; cdata_wr = 20'h12345;
        tick;
        cwr = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL csel_err_set: got %0b want 1", err); end
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'h005; #1;
        n_cmp++; if (cdata_rd !== 20'hA5005) begin n_bad++; $display("FAIL csel_err_l0_kept: got %0h want a5005", cdata_rd); end
        csel = 3'b011; #1;
        n_cmp++; if (cdata_rd !== 20'hFFFFF) begin n_bad++; $display("FAIL csel_err_l1_kept: got %0h want fffff", cdata_rd); end
        csel = 3'b010; #1;
        n_cmp++; if (cdata_rd !== 20'h00000) begin n_bad++; $display("FAIL rd_illegal_zero: got %0h want 0", cdata_rd); end
        crd = 1'b0; csel = 3'b000;
        tick; tick;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", err); end
    endtask

    task automatic test_dump;
        int idx, cyc, bubbles;
        bit prev_hs;
        logic          e_sel;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        busy = 1'b0;
        tick;
        n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL dump_entry_valid_low: got %0b want 0", dump_valid); end
        tick;
        n_cmp++; if (dump_valid !== 1'b1) begin n_bad++; $display("FAIL dump_valid_rise: got %0b want 1", dump_valid); end
        n_cmp++; if (dump_data !== 20'hA5000) begin n_bad++; $display("FAIL dump_first_word: got %0h want a5000", dump_data); end
        idx = 0; cyc = 0; bubbles = 0; prev_hs = 1'b0;
        while (!done && cyc < 20000) begin
            dump_ready = ((cyc % 2) == 0);
            if (dump_valid) begin
                e_sel  = (idx >= 4096);
                e_addr = (idx < 4096) ? AW'(idx) : AW'(idx - 4096);
                e_data = (idx < 4096) ? exp_l0[idx] : (idx < 5120 ? exp_l1[idx - 4096] : 20'h00000);
                n_cmp++;
                if (idx >= 5120 || dump_sel !== e_sel || dump_addr !== e_addr || dump_data !== e_data) begin
                    n_bad++;
                    $display("FAIL dump_word %0d: got sel=%0b addr=%0h data=%0h want sel=%0b addr=%0h data=%0h",
                             idx, dump_sel, dump_addr, dump_data, e_sel, e_addr, e_data);
                end
                if (dump_ready) idx++;
                prev_hs = dump_ready;
            end else begin
                if (prev_hs) bubbles++;
                prev_hs = 1'b0;
            end
            tick;
            cyc++;
        end
        dump_ready = 1'b0;
        n_cmp++; if (idx !== 5120) begin n_bad++; $display("FAIL dump_handshakes: got %0d want 5120", idx); end
        n_cmp++; if (bubbles !== 0) begin n_bad++; $display("FAIL dump_bubbles: got %0d want 0", bubbles); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dump_done: got %0b want 1", done); end
        n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL fin_valid_low: got %0b want 0", dump_valid); end
        tick; tick;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_sticky: got %0b want 1", done); end
    endtask

    task automatic test_reset_mid_dump;
        int acc, cyc;
        idle_inputs;
        reset = 1'b0;
        #7;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst2_done: got %0b want 0", done); end
        @(negedge clk);
        reset = 1'b1;
        tick;
        load_image(1'b0, 20'h40000, acc);
        n_cmp++; if (acc !== 4096) begin n_bad++; $display("FAIL load2_accepts: got %0d want 4096", acc); end
        iaddr = 12'h0A5; #1;
        n_cmp++; if (idata !== 20'h400A5) begin n_bad++; $display("FAIL load2_idata: got %0h want 400a5", idata); end
        tick; tick; tick; tick;
        busy = 1'b0;
        tick;
        dump_ready = 1'b1;
        cyc = 0;
        while (!(dump_valid && dump_addr == 12'd300) && cyc < 1000) begin
            tick;
            cyc++;
        end
        n_cmp++; if (dump_data !== 20'hA512C) begin n_bad++; $display("FAIL dump_word_300: got %0h want a512c", dump_data); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %0b want 0", dump_valid); end
        n_cmp++; if (dump_addr !== 12'h000) begin n_bad++; $display("FAIL async_rst_addr: got %0h want 0", dump_addr); end
        idle_inputs;
        tick;
        @(negedge clk);
        reset = 1'b1;
        tick;
        n_cmp++; if (img_ready !== 1'b1) begin n_bad++; $display("FAIL rst3_img_ready: got %0b want 1", img_ready); end
    endtask

    task automatic test_load_restart;
        img_valid = 1'b1;
        img_data = 20'hAAAAA; tick;
        img_data = 20'hBBBBB; tick;
        img_data = 20'hCCCCC; tick;
        img_valid = 1'b0;
        iaddr = 12'h000; #1;
        n_cmp++; if (idata !== 20'hAAAAA) begin n_bad++; $display("FAIL restart_img0: got %0h want aaaaa", idata); end
        iaddr = 12'h001; #1;
        n_cmp++; if (idata !== 20'hBBBBB) begin n_bad++; $display("FAIL restart_img1: got %0h want bbbbb", idata); end
        iaddr = 12'h002; #1;
        n_cmp++; if (idata !== 20'hCCCCC) begin n_bad++; $display("FAIL restart_img2: got %0h want ccccc", idata); end
        iaddr = 12'h003; #1;
        n_cmp++; if (idata !== 20'h40003) begin n_bad++; $display("FAIL restart_img3_old: got %0h want 40003", idata); end
    endtask

    task automatic test_cwr_in_load;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL load_err_pre: got %0b want 0", err); end
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h7FF; cdata_wr = 20'h55555;
        tick;
        cwr = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL load_cwr_err: got %0b want 1", err); end
        crd = 1'b1; caddr_rd = 12'h7FF; #1;
        n_cmp++; if (cdata_rd !== 20'h13100) begin n_bad++; $display("FAIL load_cwr_l0_kept: got %0h want 13100", cdata_rd); end
        crd = 1'b0;
        n_cmp++; if (img_ready !== 1'b1) begin n_bad++; $display("FAIL load_cwr_img_ready: got %0b want 1", img_ready); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_run_blanking;
        test_layer_fill;
        test_layer_rw;
        test_csel_err;
        test_dump;
        test_reset_mid_dump;
        test_load_restart;
        test_cwr_in_load;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Memory-side responder for the convolution accelerator interface.
- Owns the 4096x20 image ROM, the 4096x20 layer-0 RAM and the 1024x20 layer-1 RAM.
- Loads the image from a host stream, issues the start pulse (ready), serves iaddr/idata and the cwr/crd/csel layer-memory traffic, and waits for busy to drop.
- Then streams both layer memories back to the host over a valid/ready port.

Parameters:
- DW, 20, data width of image and layer words (signed Q4.16)
- AW, 12, address width of image/L0 (depth 2^AW = 4096)
- L1_AW, 10, address width of L1 (depth 1024)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (clears all state when 0)
- img_valid  in  1  host image word valid
- img_data  in  DW  host image word
- img_ready  out  1  responder accepts image word
- ready  out  1  start pulse to accelerator
- busy  in  1  accelerator busy
- iaddr  in  AW  image read address
- idata  out  DW  image read data
- csel  in  3  layer select: 3'b001 = L0, 3'b011 = L1
- cwr  in  1  layer write enable
- caddr_wr  in  AW  write address (L1 uses [L1_AW-1:0])
- cdata_wr  in  DW  write data
- crd  in  1  layer read enable
- caddr_rd  in  AW  read address (L1 uses [L1_AW-1:0])
- cdata_rd  out  DW  layer read data
- dump_valid  out  1  dump word valid
- dump_ready  in  1  host accepts dump word
- dump_sel  out  1  0 = L0 word, 1 = L1 word
- dump_addr  out  AW  address of dump word (L1 zero-extended)
- dump_data  out  DW  dump word
- done  out  1  dump complete, sticky
- err  out  1  sticky protocol error

Behaviour:

Reset values:
- reset=0 asynchronously forces state=LOAD, load counter=0, dump counter=0.
- Outputs: img_ready=0, ready=0, dump_valid=0, dump_sel=0, dump_addr=0, dump_data=0, done=0, err=0.
- Memory arrays are not cleared.
- Reset mid-operation abandons the current phase; next phase is LOAD from address 0.

State machine (LOAD -> START -> RUN -> DUMP_L0 -> DUMP_L1 -> FIN):
- LOAD:
  - img_ready=1 (registered; rises the first cycle after reset release).
  - On img_valid & img_ready: img[cnt] <= img_data; cnt++.
  - The accept of word 4095 moves to START; img_ready=0 from that next cycle.
- START:
  - ready=1 for exactly one cycle, then RUN.
- RUN:
  - img_valid is ignored (img_ready=0).
  - The first 2 cycles of RUN are a blanking window.
  - After the blanking window, busy sampled 0 moves to DUMP_L0.
- DUMP_L0:
  - Presents L0[0..4095] in address order with dump_sel=0.
  - dump_valid rises the cycle after state entry.
  - While dump_valid & !dump_ready: data, address and sel are held stable.
  - On handshake the next word appears on the following cycle, so back-to-back throughput is 1 word/cycle.
  - The handshake of address 4095 moves to DUMP_L1 with no bubble; the L1 word at address 0 follows directly.
- DUMP_L1:
  - Presents L1[0..1023] with dump_sel=1.
  - The handshake of address 1023 moves to FIN.
- FIN:
  - dump_valid=0, done=1; held until reset.

Image read port:
- idata = img[iaddr], combinational, in every state.
- Content is valid only after LOAD completes.

Layer writes:
- Committed on the rising edge when cwr=1 and state=RUN.
- csel=001: L0[caddr_wr] <= cdata_wr.
- csel=011: L1[caddr_wr[9:0]] <= cdata_wr.
- Any other csel: no write, err<=1.
- cwr=1 outside RUN: no write, err<=1.

Layer reads:
- cdata_rd is combinational.
- crd=1 & csel=001: L0[caddr_rd].
- crd=1 & csel=011: L1[caddr_rd[9:0]].
- Otherwise cdata_rd=0.
- crd=1 with an illegal csel also sets err.

Simultaneous events:
- cwr and crd to the same address in the same cycle: cdata_rd shows the old content; the new value is visible from the next cycle.
- ready and busy are never both examined in the same state. busy during LOAD/START is ignored.

Test Plan:
- Load 4096 words img[i]=i, with img_valid deasserted every 3rd cycle -> exactly 4096 accepts; img_ready=0 after the last; ready high exactly 1 cycle; idata at iaddr=0x0A5 reads 0x000A5.
- In RUN: cwr=1, csel=001, caddr_wr=0x7FF, cdata_wr=0x13100; next cycle crd=1, caddr_rd=0x7FF -> cdata_rd=0x13100. Same cycle with crd=1 -> cdata_rd = old value.
- csel=011, caddr_wr=0xC05, data 0xFFFFF -> L1[0x005]=0xFFFFF. csel=010 with cwr=1 -> no memory change, err=1 sticky.
- busy dropped at the 1st RUN cycle -> still in RUN. busy dropped later -> dump_valid next cycle with L0[0]. dump_ready toggled 1010... -> each word held until accepted; 5120 handshakes total, sel switches at the L0->L1 transition, done=1 after L1[1023].
- reset=0 during DUMP_L0 at address 300 -> dump_valid=0 immediately (asynchronous); after release img_ready=1 and the counter restarts at 0.
- cwr=1 pulsed during LOAD -> err=1, L0 unchanged.
